// File: rtl/sdbank_switch_multi.sv
// N-bank frame-buffer arbiter between camera writer and LCD reader; reader always takes the newest frame.
// Define SDBANK_STATS_EN to build the drop/repeat counters; otherwise both outputs read zero.
module sdbank_switch_multi #(
  parameter int BANK_NUM    = 3,
  parameter int BANK_W      = 2,
  parameter int LOAD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bank_valid,
  input  logic              frame_write_done,
  input  logic              frame_read_done,
  output logic [BANK_W-1:0] wr_bank,
  output logic [BANK_W-1:0] rd_bank,
  output logic              wr_load,
  output logic              rd_load,
  output logic              fresh_valid,
  output logic [BANK_W-1:0] latest_bank,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       repeat_cnt
);

  // state    | meaning
  // W_IDLE   | waiting for a camera frame-valid rise
  // W_LOAD   | wr_load pulse in progress
  // W_ACTIVE | writing a frame into wr_bank
  // R_LOAD   | rd_load pulse in progress
  // R_ACTIVE | reading a frame from rd_bank
  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_LOAD   = 2'd1;
  localparam logic [1:0] W_ACTIVE = 2'd2;
  localparam logic [0:0] R_LOAD   = 1'b0;
  localparam logic [0:0] R_ACTIVE = 1'b1;

  logic [1:0]        w_state;
  logic [0:0]        r_state;
  logic [3:0]        w_cnt, r_cnt;
  logic              bv_s1, bv_s2, bv_s3, rise_q;
  logic              wdone, rdone, fresh_mid, block, swap, found;
  logic [BANK_W-1:0] lat_n, rd_n, wr_pick, wr_n, cand;

  function automatic logic [BANK_W-1:0] bank_add(input logic [BANK_W-1:0] b, input int k);
    int s;
    s = int'(b) + k;
    return BANK_W'(s % BANK_NUM);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bv_s1  <= 1'b0;
      bv_s2  <= 1'b0;
      bv_s3  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      bv_s1  <= bank_valid;
      bv_s2  <= bv_s1;
      bv_s3  <= bv_s2;
      rise_q <= bv_s2 & ~bv_s3;
    end
  end

  // Write completion is resolved before the read decision so a simultaneous reader sees it.
  always_comb begin
    wdone     = (w_state == W_ACTIVE) && frame_write_done;
    rdone     = (r_state == R_ACTIVE) && frame_read_done;
    lat_n     = wdone ? wr_bank : latest_bank;
    fresh_mid = wdone | fresh_valid;
    block     = !wdone && (w_state != W_IDLE) && (wr_bank == latest_bank);
    swap      = rdone && fresh_mid && !block;
    rd_n      = swap ? lat_n : rd_bank;
    wr_pick   = wr_bank;
    found     = 1'b0;
    cand      = wr_bank;
    if (wdone) begin
      for (int k = 1; k < BANK_NUM; k++) begin
        cand = bank_add(wr_bank, k);
        if (!found && cand != rd_n && cand != lat_n) begin
          wr_pick = cand;
          found   = 1'b1;
        end
      end
    end
    wr_n = (swap && rd_n == wr_pick) ? rd_bank : wr_pick;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_cnt   <= 4'd0;
      wr_load <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (rise_q) begin
          w_state <= W_LOAD;
          wr_load <= 1'b1;
          w_cnt   <= 4'(LOAD_CYCLES - 1);
        end
        W_LOAD: if (w_cnt != 4'd0) begin
          w_cnt <= w_cnt - 4'd1;
        end else begin
          wr_load <= 1'b0;
          w_state <= W_ACTIVE;
        end
        W_ACTIVE: if (frame_write_done) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= R_LOAD;
      r_cnt   <= 4'(LOAD_CYCLES);
      rd_load <= 1'b0;
    end else begin
      case (r_state)
        R_LOAD: if (r_cnt != 4'd0) begin
          rd_load <= 1'b1;
          r_cnt   <= r_cnt - 4'd1;
        end else begin
          rd_load <= 1'b0;
          r_state <= R_ACTIVE;
        end
        default: if (frame_read_done) begin
          r_state <= R_LOAD;
          r_cnt   <= 4'(LOAD_CYCLES);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank     <= '0;
      rd_bank     <= BANK_W'(BANK_NUM - 1);
      latest_bank <= '0;
      fresh_valid <= 1'b0;
    end else begin
      wr_bank     <= wr_n;
      rd_bank     <= rd_n;
      latest_bank <= lat_n;
      fresh_valid <= fresh_mid && !swap;
    end
  end

`ifdef SDBANK_STATS_EN
  logic        drop_inc, rep_inc;
  logic [15:0] drop_q, rep_q;

  assign drop_inc = wdone && fresh_valid;
  assign rep_inc  = rdone && !swap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= 16'd0;
      rep_q  <= 16'd0;
    end else begin
      if (drop_inc && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      if (rep_inc && rep_q != 16'hFFFF) rep_q <= rep_q + 16'd1;
    end
  end

  assign drop_cnt   = drop_q;
  assign repeat_cnt = rep_q;
`else
  assign drop_cnt   = 16'd0;
  assign repeat_cnt = 16'd0;
`endif

endmodule
